// File: rtl/mdr_result_bcd_if.sv
// Bus between the multiplier/divider/sqrt unit, the BCD result stage and the display driver.
// The master drives the arithmetic results; the slave (BCD stage) returns display data.
interface mdr_result_bcd_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) ();
    logic                  ready_MDR;
    logic [WIDTH-1:0]      result;
    logic [WIDTH-1:0]      reminder;
    logic                  sign_MDR;
    logic                  sel;
    logic [4*DIGITS-1:0]   bcd;
    logic                  sign_out;
    logic                  valid;
    logic                  busy;

    modport master (
        output ready_MDR, result, reminder, sign_MDR, sel,
        input  bcd, sign_out, valid, busy
    );

    modport slave (
        input  ready_MDR, result, reminder, sign_MDR, sel,
        output bcd, sign_out, valid, busy
    );
endinterface

// File: rtl/mdr_result_bcd.sv
// Captures the arithmetic unit's result/remainder on ready rise (or a source switch)
// and converts it to packed BCD with a one-bit-per-clock double-dabble engine.
module mdr_result_bcd #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10,
    parameter int CW     = 6
) (
    input  logic              clk,
    input  logic              reset,
    mdr_result_bcd_if.slave   bus
);
    localparam int BW = 4 * DIGITS;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              sel_q, sel_d;
    logic              have_q, have_d;
    logic [WIDTH-1:0]  res_hold_q, res_hold_d;
    logic [WIDTH-1:0]  rem_hold_q, rem_hold_d;
    logic              sign_hold_q, sign_hold_d;
    logic              sign_cap_q, sign_cap_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              sign_out_q, sign_out_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    logic              rise, tog, start;
    logic [WIDTH-1:0]  operand;
    logic              sign_src;
    logic [BW-1:0]     adj;
    logic [BW+WIDTH-1:0] cat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            sel_q       <= 1'b0;
            have_q      <= 1'b0;
            res_hold_q  <= '0;
            rem_hold_q  <= '0;
            sign_hold_q <= 1'b0;
            sign_cap_q  <= 1'b0;
            sr_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            sign_out_q  <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            sel_q       <= sel_d;
            have_q      <= have_d;
            res_hold_q  <= res_hold_d;
            rem_hold_q  <= rem_hold_d;
            sign_hold_q <= sign_hold_d;
            sign_cap_q  <= sign_cap_d;
            sr_q        <= sr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            sign_out_q  <= sign_out_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ready_d     = bus.ready_MDR;
        sel_d       = bus.sel;
        have_d      = have_q;
        res_hold_d  = res_hold_q;
        rem_hold_d  = rem_hold_q;
        sign_hold_d = sign_hold_q;
        sign_cap_d  = sign_cap_q;
        sr_d        = sr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        sign_out_d  = sign_out_q;
        valid_d     = valid_q;
        busy_d      = busy_q;

        rise  = bus.ready_MDR & ~ready_q;
        tog   = (bus.sel != sel_q) & have_q;
        start = rise | tog;

        // A fresh capture bypasses the holding registers so it starts on the same edge.
        operand  = rise ? (bus.sel ? bus.reminder : bus.result)
                        : (bus.sel ? rem_hold_q   : res_hold_q);
        sign_src = rise ? bus.sign_MDR : sign_hold_q;

        adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        cat = {adj, sr_q} << 1;

        if (rise) begin
            res_hold_d  = bus.result;
            rem_hold_d  = bus.reminder;
            sign_hold_d = bus.sign_MDR;
            have_d      = 1'b1;
        end

        if (start) begin
            state_d    = SHIFT;
            sr_d       = operand;
            acc_d      = '0;
            cnt_d      = CW'(WIDTH);
            sign_cap_d = ~bus.sel & sign_src;
            valid_d    = 1'b0;
            busy_d     = 1'b1;
        end else if (state_q == SHIFT) begin
            acc_d = cat[BW+WIDTH-1:WIDTH];
            sr_d  = cat[WIDTH-1:0];
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                bcd_d      = cat[BW+WIDTH-1:WIDTH];
                sign_out_d = sign_cap_q;
                valid_d    = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
        end
    end

    assign bus.bcd      = bcd_q;
    assign bus.sign_out = sign_out_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mdr_result_bcd.sv
// Directed bench for mdr_result_bcd: hand-computed BCD values, latency, abort and reset cases.
module tb_mdr_result_bcd;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    int   busy_cnt;

    mdr_result_bcd_if #(.WIDTH(32), .DIGITS(10)) bif ();

    mdr_result_bcd #(.WIDTH(32), .DIGITS(10), .CW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called right after the start edge: checks busy through the conversion and the result.
    task automatic wait_conv(input string tag, input logic [39:0] exp_bcd, input logic exp_sign);
        chk({tag, " busy@start"}, 64'(bif.busy), 64'd1);
        repeat (31) tick();
        chk({tag, " busy@31"}, 64'(bif.busy), 64'd1);
        chk({tag, " valid@31"}, 64'(bif.valid), 64'd0);
        tick();
        chk({tag, " valid"}, 64'(bif.valid), 64'd1);
        chk({tag, " busy"}, 64'(bif.busy), 64'd0);
        chk({tag, " bcd"}, 64'(bif.bcd), 64'(exp_bcd));
        chk({tag, " sign"}, 64'(bif.sign_out), 64'(exp_sign));
    endtask

    task automatic capture(input logic [31:0] res, input logic [31:0] rem, input logic sgn);
        bif.ready_MDR = 1'b0;
        tick();
        bif.result    = res;
        bif.reminder  = rem;
        bif.sign_MDR  = sgn;
        bif.ready_MDR = 1'b1;
        tick();
    endtask

    initial begin
        reset         = 1'b1;
        bif.ready_MDR = 1'b0;
        bif.result    = '0;
        bif.reminder  = '0;
        bif.sign_MDR  = 1'b0;
        bif.sel       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst bcd", 64'(bif.bcd), 64'd0);
        chk("rst valid", 64'(bif.valid), 64'd0);
        chk("rst busy", 64'(bif.busy), 64'd0);
        chk("rst sign", 64'(bif.sign_out), 64'd0);

        capture(32'd12345, 32'd0, 1'b1);
        wait_conv("12345", 40'h0000012345, 1'b1);

        capture(32'hFFFF_FFFF, 32'd0, 1'b0);
        wait_conv("max", 40'h4294967295, 1'b0);

        capture(32'd0, 32'd0, 1'b0);
        wait_conv("zero", 40'h0000000000, 1'b0);

        // Source switch while ready stays high reuses the held operands.
        capture(32'd100, 32'd7, 1'b1);
        wait_conv("100", 40'h0000000100, 1'b1);
        bif.sel = 1'b1;
        tick();
        wait_conv("sel rem", 40'h0000000007, 1'b0);
        bif.sel = 1'b0;
        tick();
        wait_conv("sel res", 40'h0000000100, 1'b1);

        // Level-high ready must give a single conversion.
        capture(32'd55, 32'd0, 1'b0);
        busy_cnt = (bif.busy === 1'b1) ? 1 : 0;
        repeat (99) begin
            tick();
            if (bif.busy === 1'b1) busy_cnt++;
        end
        chk("hold busy cycles", 64'(busy_cnt), 64'd32);
        chk("hold bcd", 64'(bif.bcd), 64'h55);
        chk("hold valid", 64'(bif.valid), 64'd1);

        // Restart mid-conversion: 999 is discarded.
        capture(32'd999, 32'd0, 1'b0);
        repeat (9) tick();
        chk("abort busy", 64'(bif.busy), 64'd1);
        capture(32'd65535, 32'd0, 1'b0);
        chk("abort bcd held", 64'(bif.bcd), 64'h55);
        chk("abort valid", 64'(bif.valid), 64'd0);
        wait_conv("65535", 40'h0000065535, 1'b0);

        // Reset mid-conversion, then a sel toggle with no held data.
        capture(32'd1234, 32'd0, 1'b1);
        repeat (14) tick();
        reset         = 1'b1;
        bif.ready_MDR = 1'b0;
        tick();
        chk("midrst bcd", 64'(bif.bcd), 64'd0);
        chk("midrst valid", 64'(bif.valid), 64'd0);
        chk("midrst busy", 64'(bif.busy), 64'd0);
        chk("midrst sign", 64'(bif.sign_out), 64'd0);
        reset   = 1'b0;
        tick();
        bif.sel = 1'b1;
        tick();
        chk("nodata busy", 64'(bif.busy), 64'd0);
        tick();
        chk("nodata busy2", 64'(bif.busy), 64'd0);
        chk("nodata valid", 64'(bif.valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
